pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 4, number of clk cycles pll_reset is held high per PLL reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, number of clk cycles to wait for lock before retrying the PLL reset.
REQ-003 SHALL have parameter STABLE_CYCLES, default 256, number of consecutive synchronized-lock-high cycles required before release.
REQ-004 SHALL have port clk, input, 1, free-running reference clock (the PLL input clock, not a PLL output).
REQ-005 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port lock, input, 1, PLL lock indicator, asynchronous to clk.
REQ-007 SHALL have port clr_sticky, input, 1, single-cycle pulse that clears lol_sticky.
REQ-008 SHALL have port pll_reset, output, 1, drives the PLL RESET input.
REQ-009 SHALL have port sys_rst, output, 1, active-high reset to downstream logic.
REQ-010 SHALL have port ready, output, 1, high when the PLL is locked and downstream logic is released.
REQ-011 SHALL have port lol_sticky, output, 1, loss-of-lock-in-RUN flag.
REQ-012 SHALL have port retry_cnt, output, 4, saturating count of lock-timeout retries.
REQ-013 SHALL have port state, output, 2, current state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.

Function
REQ-014 SHALL synchronize lock through two clk flops (lock_sync), giving 2 cycles of latency.
REQ-015 SHALL use one 24-bit cycle counter cnt that is cleared to 0 on every state entry and increments each cycle in the state; all parameters SHALL satisfy 1 <= P < 2^24.
REQ-016 SHALL decode outputs from registered state only: pll_reset = (state==PLL_RST), sys_rst = (state!=RUN), ready = (state==RUN).
REQ-017 PLL_RST SHALL transition to WAIT_LOCK when cnt==PLL_RST_CYCLES-1, so pll_reset stays high exactly PLL_RST_CYCLES cycles.
REQ-018 WAIT_LOCK SHALL go to STABLE when lock_sync==1; otherwise, when cnt==LOCK_TIMEOUT-1, it SHALL go to PLL_RST and increment retry_cnt, saturating at 15.
REQ-019 In WAIT_LOCK, lock_sync==1 SHALL take priority over timeout in the same cycle.
REQ-020 STABLE SHALL go to WAIT_LOCK on any cycle with lock_sync==0, and SHALL go to RUN when cnt==STABLE_CYCLES-1 with lock_sync==1.
REQ-021 RUN SHALL go to PLL_RST and set lol_sticky=1 on any cycle with lock_sync==0.
REQ-022 RUN SHALL NOT change retry_cnt.
REQ-023 clr_sticky SHALL clear lol_sticky on the next edge; if it coincides with a set event, the set SHALL win.
REQ-024 A lock glitch of any length that is seen on lock_sync SHALL NOT be filtered in STABLE or RUN.
REQ-025 A lock pulse shorter than one clk cycle MAY be missed by the synchronizer.

Reset
REQ-026 While rst is high, on each clk edge: state=PLL_RST, cnt=0, sync flops=0, lol_sticky=0, retry_cnt=0.
REQ-027 Consequently, while rst is high, pll_reset=1, sys_rst=1, ready=0.
REQ-028 rst asserted in any state, including mid-RUN, SHALL take effect at the next edge, overriding all other transitions.
REQ-029 After rst is released, the full PLL_RST sequence SHALL restart from cnt=0.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8)
REQ-030 Release rst with lock held 1 -> pll_reset high 4 cycles, WAIT_LOCK 1 cycle, STABLE 8 cycles, then ready=1 and sys_rst=0 on the 14th cycle after release; retry_cnt=0.
REQ-031 Hold lock=0 -> pll_reset pulses 4 cycles every 20 cycles; retry_cnt steps 1,2,...,15 and stays at 15; ready never rises.
REQ-032 Drive lock low for 3 cycles during STABLE at cnt=5 -> return to WAIT_LOCK; after lock returns, a full 8-cycle STABLE window is required before ready=1.
REQ-033 In RUN, drop lock -> 3 cycles later state=PLL_RST, ready=0, sys_rst=1, lol_sticky=1, pll_reset high 4 cycles; a clr_sticky pulse later -> lol_sticky=0; clr_sticky coinciding with the set cycle -> lol_sticky=1.
REQ-034 Assert rst for 1 cycle mid-RUN with retry_cnt=3 and lol_sticky=1 -> next edge state=0, retry_cnt=0, lol_sticky=0, ready=0; the REQ-030 sequence then repeats.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock, then releases sys_rst.
// Outputs are decoded from the registered state. A lock drop is acted on 3 edges after it appears at the pin.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STABLE_CYCLES  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    input  logic       clr_sticky,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       lol_sticky,
    output logic [3:0] retry_cnt,
    output logic [1:0] state
);

    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam logic [23:0] C_RST_LAST    = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] C_TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] C_STABLE_LAST = 24'(STABLE_CYCLES - 1);

    logic        r_lock_meta;
    logic        r_lock_sync;
    logic [1:0]  r_state;
    logic [23:0] r_cnt;
    logic        r_lol;
    logic [3:0]  r_retry;

    logic [1:0]  w_state_nxt;
    logic        w_retry_inc;
    logic        w_lol_set;

    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_lol_set   = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == C_RST_LAST)
                    w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as acquired.
                if (r_lock_sync) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!r_lock_sync)
                    w_state_nxt = S_WAIT_LOCK;
                else if (r_cnt == C_STABLE_LAST)
                    w_state_nxt = S_RUN;
            end
            default: begin
                if (!r_lock_sync) begin
                    w_state_nxt = S_PLL_RST;
                    w_lol_set   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_state     <= S_PLL_RST;
            r_cnt       <= 24'd0;
            r_lol       <= 1'b0;
            r_retry     <= 4'd0;
        end else begin
            r_lock_meta <= lock;
            r_lock_sync <= r_lock_meta;
            r_state     <= w_state_nxt;
            // Every transition changes state, so a state change marks entry.
            if (w_state_nxt != r_state)
                r_cnt <= 24'd0;
            else
                r_cnt <= r_cnt + 24'd1;
            if (w_lol_set)
                r_lol <= 1'b1;
            else if (clr_sticky)
                r_lol <= 1'b0;
            if (w_retry_inc && (r_retry != 4'hF))
                r_retry <= r_retry + 4'd1;
        end
    end

    assign pll_reset  = (r_state == S_PLL_RST);
    assign sys_rst    = (r_state != S_RUN);
    assign ready      = (r_state == S_RUN);
    assign lol_sticky = r_lol;
    assign retry_cnt  = r_retry;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock traffic against a cycle model.
module tb_pll_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 16;
    localparam int P_ST  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       clr_sticky = 1'b0;
    logic       pll_reset, sys_rst, ready, lol_sticky;
    logic [3:0] retry_cnt;
    logic [1:0] state;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .STABLE_CYCLES (P_ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock      (lock),
        .clr_sticky(clr_sticky),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lol_sticky(lol_sticky),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    int checks = 0;
    int failures = 0;

    // Reference: phase 0..3 = reset pulse, waiting, stabilising, running; age = cycles already spent in phase.
    int m_state = 0;
    int m_age   = 0;
    int m_retry = 0;
    bit m_lol   = 1'b0;
    bit m_h0    = 1'b0;
    bit m_h1    = 1'b0;

    wire [9:0] dut_vec = {state, pll_reset, sys_rst, ready, lol_sticky, retry_cnt};

    function automatic logic [9:0] exp_vec();
        return {2'(m_state), m_state == 0, m_state != 3, m_state == 3, m_lol, 4'(m_retry)};
    endfunction

    task automatic model_step();
        int nxt;
        bit seen;
        if (rst) begin
            m_state = 0; m_age = 0; m_h0 = 0; m_h1 = 0; m_lol = 0; m_retry = 0;
        end else begin
            seen = m_h1;
            nxt  = m_state;
            if (m_state == 0) begin
                if (m_age + 1 >= P_RST) nxt = 1;
            end else if (m_state == 1) begin
                if (seen) nxt = 2;
                else if (m_age + 1 >= P_TO) begin
                    nxt = 0;
                    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                end
            end else if (m_state == 2) begin
                if (!seen) nxt = 1;
                else if (m_age + 1 >= P_ST) nxt = 3;
            end else if (!seen) begin
                nxt = 0;
            end
            if (m_state == 3 && !seen) m_lol = 1;
            else if (clr_sticky) m_lol = 0;
            m_age   = (nxt != m_state) ? 0 : m_age + 1;
            m_state = nxt;
            m_h1    = m_h0;
            m_h0    = lock;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_ready(input int limit, output int n);
        n = 0;
        while (!ready && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lock = 1'b0; clr_sticky = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec !== 10'b00_1_1_0_0_0000) begin
            failures++; $display("FAIL reset_state got=%b want=%b", dut_vec, 10'b00_1_1_0_0_0000);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_model got=%b want=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lock_acquire();
        int first_ready = -1;
        int rst_hi = 0;
        lock = 1'b1;
        pulse_reset();
        if (pll_reset) rst_hi++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pll_reset) rst_hi++;
            if (ready && first_ready < 0) first_ready = i;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL acquire_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (first_ready != 13) begin
            failures++; $display("FAIL acquire_ready_cycle got=%0d want=13", first_ready);
        end
        checks++;
        if (rst_hi != 4) begin
            failures++; $display("FAIL acquire_pll_reset_len got=%0d want=4", rst_hi);
        end
        checks++;
        if (retry_cnt !== 4'd0 || sys_rst !== 1'b0) begin
            failures++; $display("FAIL acquire_final retry=%0d sys_rst=%b want 0/0", retry_cnt, sys_rst);
        end
    endtask

    task automatic test_timeout_retry();
        int r;
        lock = 1'b0;
        pulse_reset();
        for (int i = 1; i <= 340; i++) begin
            tick();
            r = (i / 20 < 15) ? i / 20 : 15;
            checks++;
            if ({pll_reset, ready, retry_cnt} !== {(i % 20) < 4, 1'b0, 4'(r)}) begin
                failures++;
                $display("FAIL timeout_seq cyc=%0d got pll=%b rdy=%b retry=%0d want pll=%b rdy=0 retry=%0d",
                         i, pll_reset, ready, retry_cnt, (i % 20) < 4, r);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL timeout_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_stable_glitch();
        int entry = -1;
        int rdy = -1;
        bit saw_wait = 0;
        logic [1:0] prev;
        lock = 1'b1;
        pulse_reset();
        for (int i = 1; i <= 10; i++) tick();
        checks++;
        if (state !== 2'd2) begin
            failures++; $display("FAIL glitch_in_stable got=%0d want=2", state);
        end
        lock = 1'b0;
        tick(); tick(); tick();
        lock = 1'b1;
        prev = state;
        for (int i = 1; i <= 40 && rdy < 0; i++) begin
            tick();
            if (state == 2'd1) saw_wait = 1;
            if (prev != 2'd2 && state == 2'd2) entry = i;
            if (ready) rdy = i;
            prev = state;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL glitch_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (!saw_wait || entry < 0 || rdy - entry != P_ST) begin
            failures++;
            $display("FAIL glitch_restable saw_wait=%0d stable_to_run=%0d want saw_wait=1 stable_to_run=%0d",
                     saw_wait, rdy - entry, P_ST);
        end
    endtask

    task automatic test_run_lol();
        int n;
        int hi = 0;
        lock = 1'b1;
        pulse_reset();
        run_until_ready(40, n);
        checks++;
        if (n >= 40) begin
            failures++; $display("FAIL lol_reach_run got=timeout want=ready");
        end
        lock = 1'b0;
        tick(); tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++; $display("FAIL lol_early_drop ready=%b want=1", ready);
        end
        tick();
        checks++;
        if ({state, ready, sys_rst, lol_sticky} !== {2'd0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL lol_drop got st=%0d rdy=%b srst=%b lol=%b want 0/0/1/1", state, ready, sys_rst, lol_sticky);
        end
        for (int i = 0; i < 8; i++) begin
            if (pll_reset) hi++;
            tick();
        end
        checks++;
        if (hi != P_RST) begin
            failures++; $display("FAIL lol_pll_reset_len got=%0d want=%0d", hi, P_RST);
        end
        lock = 1'b1;
        run_until_ready(60, n);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++;
        if (lol_sticky !== 1'b0 || ready !== 1'b1) begin
            failures++; $display("FAIL lol_clear got lol=%b rdy=%b want 0/1", lol_sticky, ready);
        end
        lock = 1'b0;
        tick(); tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++;
        if (lol_sticky !== 1'b1 || state !== 2'd0) begin
            failures++; $display("FAIL lol_set_wins got lol=%b st=%0d want 1/0", lol_sticky, state);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL lol_model got=%b want=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int first_ready = -1;
        lock = 1'b0;
        pulse_reset();
        for (int i = 0; i < 60; i++) tick();
        lock = 1'b1;
        run_until_ready(60, n);
        lock = 1'b0;
        tick(); tick(); tick();
        lock = 1'b1;
        run_until_ready(60, n);
        checks++;
        if ({ready, lol_sticky, retry_cnt} !== {1'b1, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL midrun_setup got rdy=%b lol=%b retry=%0d want 1/1/3", ready, lol_sticky, retry_cnt);
        end
        pulse_reset();
        checks++;
        if (dut_vec !== 10'b00_1_1_0_0_0000) begin
            failures++; $display("FAIL midrun_reset got=%b want=%b", dut_vec, 10'b00_1_1_0_0_0000);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ready && first_ready < 0) first_ready = i;
        end
        checks++;
        if (first_ready != 13) begin
            failures++; $display("FAIL midrun_reacquire got=%0d want=13", first_ready);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lock = ($urandom_range(0, 99) < 65);
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 60);
            end
            hold--;
            clr_sticky = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL random_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0;
        clr_sticky = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_timeout_retry();
        test_stable_glitch();
        test_run_lol();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
